mux_scan_ctrl: RTL and testbench

Sequencer for the five-channel, 3-bit-wide display mux path. It generates the channel select and a registered copy of the selected channel's data for the octal 7-segment decoder. There are two modes. Auto-scan rotates through the channels on a fixed dwell timer. Manual mode advances one channel per debounced push-button press. It sits between the board inputs (switches/keys) and the 7-seg decoder, replacing switch-driven channel selection.

---
 rtl/mux_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: channel sequencer for the multi-channel 3-bit display mux.
// Auto mode rotates SEL on a dwell timer. Manual mode advances SEL once per
// debounced step-button press. DOUT is a registered copy of the selected
// channel's data, and TICK marks every SEL advance.
module mux_scan_ctrl #(
    parameter int NUM_CH         = 5,
    parameter int DWELL_CYCLES   = 50000000,
    parameter int LOCKOUT_CYCLES = 1000000
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY0,
    input  logic [3*NUM_CH-1:0]   DIN,
    input  logic                  MODE,
    input  logic                  HOLD,
    input  logic                  STEP_N,
    output logic [2:0]            SEL,
    output logic [2:0]            DOUT,
    output logic                  TICK
);

    // Each counter only needs to reach its parameter minus one.
    localparam int DW = (DWELL_CYCLES   > 1) ? $clog2(DWELL_CYCLES)   : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_CH    = 3'(NUM_CH - 1);

    logic          step_s1, step_s2, step_s3;
    logic          step_fall;
    logic          step_pulse;
    logic [LW-1:0] lock_cnt;
    logic          mode_q;
    logic          mode_chg;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_done;
    logic          advance;
    logic [2:0]    sel_q;
    logic [2:0]    dout_q;
    logic [2:0]    din_sel;

    // Two-flop synchronizer for the raw button, plus one stage for edge detection.
    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking assignments here would collapse the chain into a single stage.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            step_s1 <= 1'b1;
            step_s2 <= 1'b1;
            step_s3 <= 1'b1;
        end else begin
            step_s1 <= STEP_N;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
        end
    end

    assign step_fall = step_s3 & ~step_s2;

    // Accept a press only when lockout has expired, then restart the lockout.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            step_pulse <= 1'b0;
            lock_cnt   <= '0;
        end else begin
            step_pulse <= step_fall && (lock_cnt == '0);
            if (step_fall && (lock_cnt == '0)) begin
                lock_cnt <= LOCK_LOAD;
            end else if (lock_cnt != '0) begin
                lock_cnt <= lock_cnt - LW'(1);
            end
        end
    end

    // Decide whether SEL moves this cycle. A mode change suppresses both sources,
    // and only the source belonging to the current mode can advance SEL.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        mode_chg   = 1'b0;
        dwell_done = 1'b0;
        advance    = 1'b0;
        mode_chg   = (MODE != mode_q);
        dwell_done = (dwell_cnt == DWELL_LAST);
        if (!mode_chg) begin
            if (MODE) advance = step_pulse;
            else      advance = dwell_done && !HOLD;
        end
    end

    // Track the mode and run the dwell timer (frozen by HOLD, parked in manual).
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            mode_q    <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            mode_q <= MODE;
            if (mode_chg || MODE) begin
                dwell_cnt <= '0;
            end else if (!HOLD) begin
                dwell_cnt <= dwell_done ? '0 : dwell_cnt + DW'(1);
            end
        end
    end

    // Pick the data slice for the current channel; out-of-range SEL reads 0.
    always_comb begin
        din_sel = 3'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == 3'(k)) din_sel = DIN[3*k +: 3];
        end
    end

    // Channel select with wrap (any out-of-range value returns to 0), and the
    // registered output data.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sel_q  <= 3'd0;
            dout_q <= 3'd0;
        end else begin
            if (advance) sel_q <= (sel_q >= LAST_CH) ? 3'd0 : sel_q + 3'd1;
            dout_q <= din_sel;
        end
    end

    assign SEL  = sel_q;
    assign DOUT = dout_q;
    assign TICK = advance;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench for mux_scan_ctrl with short timers
// (NUM_CH=5, DWELL_CYCLES=4, LOCKOUT_CYCLES=3). Inputs change and outputs are
// sampled 2 time units after each rising edge.
module tb_mux_scan_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        KEY0;
    logic [14:0] DIN;
    logic        MODE;
    logic        HOLD;
    logic        STEP_N;
    logic [2:0]  SEL;
    logic [2:0]  DOUT;
    logic        TICK;

    int total = 0;
    int bad   = 0;

    mux_scan_ctrl #(
        .NUM_CH         (5),
        .DWELL_CYCLES   (4),
        .LOCKOUT_CYCLES (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .DIN      (DIN),
        .MODE     (MODE),
        .HOLD     (HOLD),
        .STEP_N   (STEP_N),
        .SEL      (SEL),
        .DOUT     (DOUT),
        .TICK     (TICK)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #2;
    endtask

    // Clean press: held low 3 edges (pulse visible), release, then idle past lockout.
    task automatic press(input logic [2:0] exp_sel, input logic [2:0] before_sel);
        STEP_N = 1'b0;
        cyc(); cyc(); cyc();
        check("press_tick", TICK, 1);
        check("press_sel_before", SEL, before_sel);
        STEP_N = 1'b1;
        cyc();
        check("press_sel_after", SEL, exp_sel);
        check("press_tick_after", TICK, 0);
        repeat (4) cyc();
    endtask

    initial begin
        KEY0   = 1'b1;
        DIN    = 15'o43210;
        MODE   = 1'b0;
        HOLD   = 1'b0;
        STEP_N = 1'b1;
        #1 KEY0 = 1'b0;
        #1;
        check("rst_sel", SEL, 0);
        check("rst_dout", DOUT, 0);
        check("rst_tick", TICK, 0);
        cyc(); cyc();
        check("rst_hold_sel", SEL, 0);
        KEY0 = 1'b1;

        // Auto scan: SEL steps every 4 edges, TICK in the terminal cycle,
        // DOUT trails SEL by one cycle. Run on to 2 clocks into channel 2.
        for (int i = 1; i <= 30; i++) begin
            cyc();
            check("auto_sel",  SEL,  (i / 4) % 5);
            check("auto_tick", TICK, (i % 4) == 3);
            check("auto_dout", DOUT, ((i - 1) / 4) % 5);
            if (i == 20) check("auto_wrap", SEL, 0);
        end

        // Hold freezes SEL and the dwell count.
        HOLD = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_sel", SEL, 2);
            check("hold_tick", TICK, 0);
        end
        HOLD = 1'b0;
        cyc();
        check("rel1_sel", SEL, 2);
        check("rel1_tick", TICK, 1);
        cyc();
        check("rel2_sel", SEL, 3);

        // Fresh start for manual mode.
        KEY0 = 1'b0;
        #1 KEY0 = 1'b1;
        check("rst2_sel", SEL, 0);
        MODE = 1'b1;
        repeat (3) cyc();
        check("man_idle_sel", SEL, 0);

        // Bouncy press: low 1, high 1, low 1, high 10 -> one advance only.
        STEP_N = 1'b0; cyc();
        STEP_N = 1'b1; cyc();
        check("bounce_tick_early", TICK, 0);
        STEP_N = 1'b0; cyc();
        check("bounce_tick", TICK, 1);
        check("bounce_sel_pre", SEL, 0);
        STEP_N = 1'b1; cyc();
        check("bounce_sel", SEL, 1);
        for (int i = 0; i < 9; i++) begin
            cyc();
            check("bounce_ignored_sel", SEL, 1);
            check("bounce_ignored_tick", TICK, 0);
        end

        // Clean presses up to channel 4, then wrap to 0.
        press(3'd2, 3'd1);
        press(3'd3, 3'd2);
        press(3'd4, 3'd3);
        press(3'd0, 3'd4);

        // Back to auto: change edge clears dwell, then a full 4-count dwell.
        MODE = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("modechg_sel", SEL, 0);
            check("modechg_tick", TICK, i == 4);
        end
        cyc();
        check("modechg_adv", SEL, 1);

        // Press in auto mode lands at dwell count 1: discarded, schedule intact.
        cyc(); cyc();
        STEP_N = 1'b0;
        cyc();
        check("astep_tick3", TICK, 1);
        check("astep_sel3", SEL, 1);
        cyc();
        check("astep_sel4", SEL, 2);
        cyc();
        check("astep_pulse_sel", SEL, 2);
        check("astep_pulse_tick", TICK, 0);
        STEP_N = 1'b1;
        cyc();
        check("astep_sel6", SEL, 2);
        check("astep_tick6", TICK, 0);
        cyc();
        check("astep_tick7", TICK, 1);
        cyc();
        check("astep_sel8", SEL, 3);
        cyc();
        check("pre_rst_dout", DOUT, 3);

        // Asynchronous reset between edges, then a full dwell on channel 0.
        #1 KEY0 = 1'b0;
        #1;
        check("arst_sel", SEL, 0);
        check("arst_dout", DOUT, 0);
        check("arst_tick", TICK, 0);
        #1 KEY0 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            check("arst_dwell_sel", SEL, 0);
            check("arst_dwell_tick", TICK, i == 3);
        end
        cyc();
        check("arst_adv", SEL, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
